// File: rtl/axi_burst_seq.sv
// AXI-style burst address sequencer: accepts a burst command and emits one
// address beat per handshake for FIXED, INCR and WRAP bursts within a 4 KB page.
module axi_burst_seq #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int IDW = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_cmd_valid,
  output logic           o_cmd_ready,
  input  logic [IDW-1:0] i_cmd_id,
  input  logic [AW-1:0]  i_cmd_addr,
  input  logic [7:0]     i_cmd_len,
  input  logic [2:0]     i_cmd_size,
  input  logic [1:0]     i_cmd_burst,
  output logic           o_beat_valid,
  input  logic           i_beat_ready,
  output logic [AW-1:0]  o_beat_addr,
  output logic [IDW-1:0] o_beat_id,
  output logic [7:0]     o_beat_idx,
  output logic           o_beat_last,
  output logic           o_cmd_err,
  output logic           o_busy
);

  typedef enum logic {S_IDLE, S_BURST} state_e;
  typedef enum logic [1:0] {
    B_FIXED = 2'b00,
    B_INCR  = 2'b01,
    B_WRAP  = 2'b10,
    B_RSVD  = 2'b11
  } burst_e;

  localparam int             MAX_SIZE  = $clog2(DW / 8);
  localparam logic [AW-1:0]  PAGE_MASK = AW'(12'hFFF);

  state_e         state_q, state_d;
  burst_e         burst_q, cmd_burst;
  logic [AW-1:0]  addr_q, start_q, next_addr;
  logic [AW-1:0]  size_bytes, aligned, incr_addr, wrap_mask, cand_addr;
  logic [IDW-1:0] id_q;
  logic [7:0]     idx_q, len_q;
  logic [2:0]     size_q;
  logic           err_q;
  logic           cmd_legal, cmd_accept, beat_hs, last_hs;

  assign cmd_burst    = burst_e'(i_cmd_burst);
  assign o_busy       = (state_q == S_BURST);
  assign o_beat_valid = o_busy;
  assign o_beat_last  = o_busy && (idx_q == len_q);
  assign o_beat_addr  = addr_q;
  assign o_beat_id    = id_q;
  assign o_beat_idx   = idx_q;
  assign o_cmd_err    = err_q;

  assign beat_hs     = o_beat_valid && i_beat_ready;
  assign last_hs     = beat_hs && o_beat_last;
  // Ready is combinational so a new command can ride on the last-beat handshake.
  assign o_cmd_ready = i_rst_n && ((state_q == S_IDLE) || last_hs);
  assign cmd_accept  = i_cmd_valid && o_cmd_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cmd_legal = 1'b1;
    if (i_cmd_size > 3'(MAX_SIZE))
      cmd_legal = 1'b0;
    if (cmd_burst == B_RSVD)
      cmd_legal = 1'b0;
    if ((cmd_burst == B_WRAP) && !(i_cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
      cmd_legal = 1'b0;
  end

  // Upper bits always come from the start address: that is both the WRAP
  // window hold and the 4 KB page hold (the latter vanishes when AW == 12).
  always_comb begin
    size_bytes = AW'(1) << size_q;
    aligned    = addr_q & ~(size_bytes - AW'(1));
    incr_addr  = aligned + size_bytes;
    wrap_mask  = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    case (burst_q)
      B_FIXED: cand_addr = addr_q;
      B_WRAP:  cand_addr = (start_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: cand_addr = incr_addr;
    endcase
    next_addr = (start_q & ~PAGE_MASK) | (cand_addr & PAGE_MASK);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_accept && cmd_legal) state_d = S_BURST;
      S_BURST: if (last_hs) state_d = (cmd_accept && cmd_legal) ? S_BURST : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      burst_q <= B_FIXED;
      addr_q  <= '0;
      start_q <= '0;
      id_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= cmd_accept && !cmd_legal;
      if (cmd_accept && cmd_legal) begin
        burst_q <= cmd_burst;
        addr_q  <= i_cmd_addr;
        start_q <= i_cmd_addr;
        id_q    <= i_cmd_id;
        idx_q   <= '0;
        len_q   <= i_cmd_len;
        size_q  <= i_cmd_size;
      end else if (beat_hs && !o_beat_last) begin
        addr_q <= next_addr;
        idx_q  <= idx_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_seq.sv
// Directed self-checking bench for axi_burst_seq (AW=32, DW=32, IDW=4).
module tb_axi_burst_seq;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_valid, beat_ready;
  logic [31:0] beat_addr;
  logic [3:0]  beat_id;
  logic [7:0]  beat_idx;
  logic        beat_last, cmd_err, busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_addr [16];

  axi_burst_seq #(.AW(32), .DW(32), .IDW(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_id    (cmd_id),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_len   (cmd_len),
    .i_cmd_size  (cmd_size),
    .i_cmd_burst (cmd_burst),
    .o_beat_valid(beat_valid),
    .i_beat_ready(beat_ready),
    .o_beat_addr (beat_addr),
    .o_beat_id   (beat_id),
    .o_beat_idx  (beat_idx),
    .o_beat_last (beat_last),
    .o_cmd_err   (cmd_err),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = size;
    cmd_burst = burst;
  endtask

  task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
    drive_cmd(id, addr, len, size, burst);
    step();
    cmd_valid = 1'b0;
  endtask

  // Walks n beats with ready held high, comparing against exp_addr[].
  task automatic check_beats(input int n, input logic [3:0] id, input string name);
    logic [45:0] act, exp;
    beat_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      act = {beat_valid, beat_last, beat_id, beat_idx, beat_addr};
      exp = {1'b1, (i == n - 1), id, 8'(i), exp_addr[i]};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s beat %0d: got {v,last,id,idx,addr}=%h expected %h", name, i, act, exp);
      end
      step();
    end
    n_checks++;
    if ({busy, beat_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s end: got {busy,valid}=%b expected 00", name, {busy, beat_valid});
    end
  endtask

  task automatic test_reset();
    logic [49:0] act;
    rst_n = 1'b0;
    repeat (3) step();
    act = {cmd_ready, beat_valid, beat_last, cmd_err, busy, beat_addr, beat_id, beat_idx};
    n_checks++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected 0", act);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({cmd_ready, beat_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: got {ready,valid,busy}=%b expected 100", {cmd_ready, beat_valid, busy});
    end
  endtask

  task automatic test_incr();
    exp_addr[0] = 32'h1002; exp_addr[1] = 32'h1004;
    exp_addr[2] = 32'h1008; exp_addr[3] = 32'h100C;
    send_cmd(4'h1, 32'h1002, 8'd3, 3'd2, INCR);
    check_beats(4, 4'h1, "incr");
  endtask

  task automatic test_wrap_fixed();
    exp_addr[0] = 32'h1034; exp_addr[1] = 32'h1038;
    exp_addr[2] = 32'h103C; exp_addr[3] = 32'h1030;
    send_cmd(4'h2, 32'h1034, 8'd3, 3'd2, WRAP);
    check_beats(4, 4'h2, "wrap");
    for (int i = 0; i < 3; i++) exp_addr[i] = 32'h2000;
    send_cmd(4'h3, 32'h2000, 8'd2, 3'd2, FIXED);
    check_beats(3, 4'h3, "fixed");
  endtask

  task automatic test_4k_hold();
    exp_addr[0] = 32'h1FF8; exp_addr[1] = 32'h1FFC;
    exp_addr[2] = 32'h1000; exp_addr[3] = 32'h1004;
    send_cmd(4'h4, 32'h1FF8, 8'd3, 3'd2, INCR);
    check_beats(4, 4'h4, "incr_4k");
  endtask

  task automatic test_backpressure();
    logic        pattern [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [40:0] act, exp;
    int          cur = 0;
    send_cmd(4'h5, 32'h3000, 8'd3, 3'd2, INCR);
    for (int c = 0; c < 8 && cur < 4; c++) begin
      beat_ready = pattern[c];
      act = {beat_valid, beat_idx, 32'h3000 + 32'(cur) * 32'd4 == beat_addr ? beat_addr : 32'hDEAD_BEEF};
      exp = {1'b1, 8'(cur), 32'h3000 + 32'(cur) * 32'd4};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL backpressure cycle %0d: got {v,idx,addr}=%h expected %h (addr seen %h)",
                 c, act, exp, beat_addr);
      end
      if (pattern[c]) cur++;
      step();
    end
    beat_ready = 1'b1;
    n_checks++;
    if (cur != 4 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure end: got beats=%0d busy=%b expected 4 and 0", cur, busy);
    end
  endtask

  task automatic test_back_to_back();
    beat_ready = 1'b1;
    send_cmd(4'h6, 32'h4000, 8'd1, 3'd2, INCR);
    step();
    drive_cmd(4'h7, 32'h5000, 8'd1, 3'd2, INCR);
    #0;
    n_checks++;
    if ({cmd_ready, beat_last, beat_addr} !== {2'b11, 32'h4004}) begin
      n_fail++;
      $display("FAIL b2b_ready: got {ready,last,addr}=%h expected %h",
               {cmd_ready, beat_last, beat_addr}, {2'b11, 32'h4004});
    end
    step();
    cmd_valid = 1'b0;
    exp_addr[0] = 32'h5000; exp_addr[1] = 32'h5004;
    check_beats(2, 4'h7, "b2b_second");
  endtask

  task automatic err_case(input string name, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    send_cmd(4'h8, addr, len, size, burst);
    n_checks++;
    if ({cmd_err, beat_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s pulse: got {err,valid,busy}=%b expected 100", name, {cmd_err, beat_valid, busy});
    end
    step();
    n_checks++;
    if ({cmd_err, beat_valid, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s after: got {err,valid,busy}=%b expected 000", name, {cmd_err, beat_valid, busy});
    end
  endtask

  task automatic test_errors();
    beat_ready = 1'b1;
    err_case("err_wrap_len2", 32'h1000, 8'd2, 3'd2, WRAP);
    err_case("err_size3", 32'h1000, 8'd3, 3'd3, INCR);
    err_case("err_burst11", 32'h1000, 8'd3, 3'd2, RSVD);
    send_cmd(4'h9, 32'h6000, 8'd0, 3'd2, INCR);
    drive_cmd(4'hA, 32'h6100, 8'd2, 3'd2, WRAP);
    #0;
    n_checks++;
    if ({cmd_ready, beat_valid, beat_last} !== 3'b111) begin
      n_fail++;
      $display("FAIL err_b2b_ready: got {ready,valid,last}=%b expected 111", {cmd_ready, beat_valid, beat_last});
    end
    step();
    cmd_valid = 1'b0;
    n_checks++;
    if ({cmd_err, beat_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL err_b2b_idle: got {err,valid,busy}=%b expected 100", {cmd_err, beat_valid, busy});
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [49:0] act;
    beat_ready = 1'b1;
    send_cmd(4'hB, 32'h7000, 8'd7, 3'd2, INCR);
    step();
    n_checks++;
    if ({beat_valid, beat_idx, beat_addr} !== {1'b1, 8'd1, 32'h7004}) begin
      n_fail++;
      $display("FAIL rst_mid_beat1: got {v,idx,addr}=%h expected %h",
               {beat_valid, beat_idx, beat_addr}, {1'b1, 8'd1, 32'h7004});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_ready_low: got %b expected 0", cmd_ready);
    end
    step();
    act = {cmd_ready, beat_valid, beat_last, cmd_err, busy, beat_addr, beat_id, beat_idx};
    n_checks++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_values: got %h expected 0", act);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({cmd_ready, beat_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_mid_release: got {ready,valid}=%b expected 10", {cmd_ready, beat_valid});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({beat_valid, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_mid_stale cycle %0d: got {valid,busy}=%b expected 00", i, {beat_valid, busy});
      end
    end
  endtask

  initial begin
    cmd_valid  = 1'b0;
    cmd_id     = '0;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_size   = '0;
    cmd_burst  = '0;
    beat_ready = 1'b1;
    test_reset();
    test_incr();
    test_wrap_fixed();
    test_4k_hold();
    test_backpressure();
    test_back_to_back();
    test_errors();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_burst_seq.md
AXI_BURST_SEQ -- requirements
Module: axi_burst_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Parameter AW, default 32: address width; legal range 12 to 64.
REQ-003 Parameter DW, default 32: data bus width; legal values 8, 16, 32, 64, 128, 256, 512, 1024.
REQ-004 Parameter IDW, default 4: transaction ID width.
REQ-005 Ports:
- i_clk  in  1  clock; all logic samples on the rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command ready.
- i_cmd_id  in  IDW  command ID.
- i_cmd_addr  in  AW  burst start address.
- i_cmd_len  in  8  beats minus 1.
- i_cmd_size  in  3  log2 of bytes per beat.
- i_cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP.
- o_beat_valid  out  1  beat valid.
- i_beat_ready  in  1  beat accepted.
- o_beat_addr  out  AW  beat address.
- o_beat_id  out  IDW  ID of the current burst.
- o_beat_idx  out  8  beat index, 0..len.
- o_beat_last  out  1  final beat of the burst.
- o_cmd_err  out  1  one-cycle pulse on a rejected command.
- o_busy  out  1  a burst is in progress.

Function
REQ-006 The state machine SHALL have two states:
- IDLE to BURST on accepting a legal command.
- BURST to IDLE on the last-beat handshake, unless a new legal command is accepted in that same cycle; in that case the state stays BURST.
REQ-007 o_cmd_ready SHALL be 1 in IDLE, and 1 in BURST only when o_beat_last is 1 and i_beat_ready is 1 (back-to-back, zero bubble).
REQ-008 Commands SHALL be accepted when i_cmd_valid and o_cmd_ready are both 1; the command fields SHALL be registered on acceptance.
REQ-009 o_beat_valid, beat 0, SHALL assert in the cycle after acceptance, with o_beat_addr equal to i_cmd_addr unmodified (unaligned start allowed for FIXED and INCR).
REQ-010 A beat handshake occurs when o_beat_valid and i_beat_ready are both 1; beat outputs SHALL stay stable while o_beat_valid is 1 and i_beat_ready is 0.
REQ-011 Next-address rules, with S = 1 << size:
- FIXED: address unchanged for every beat.
- INCR: next = (addr with its low log2(S) bits cleared) + S.
- WRAP: let W = (len+1)*S. The bits below log2(W) SHALL follow the INCR result modulo W; all bits at or above log2(W) SHALL be held from the start address.
REQ-012 For all burst types, address bits AW-1:12 SHALL be held at the start value, so a burst never crosses a 4 KB boundary; when AW == 12 this clause is void.
REQ-013 o_beat_idx SHALL be 0 on beat 0 and increment by 1 per handshake; o_beat_last SHALL equal (o_beat_idx == len).
REQ-014 A command SHALL be illegal if size > log2(DW/8), if burst == 11, or if burst is WRAP with len not in {1, 3, 7, 15}; a WRAP start address need not be size-aligned.
REQ-015 An illegal command SHALL be accepted (handshake completes), produce no beats, and pulse o_cmd_err for exactly one cycle, in the cycle after acceptance.
REQ-016 An illegal command accepted back-to-back at a last beat SHALL return the state to IDLE after that last beat.
REQ-017 o_busy SHALL equal (state == BURST).
REQ-018 Address arithmetic SHALL be AW bits wide; any carry out of bit AW-1 SHALL be discarded.
REQ-019 Each handshake SHALL advance exactly one beat; no beat is skipped or repeated under any i_beat_ready pattern.

Reset
REQ-020 While i_rst_n is 0 at a clock edge, the next state SHALL be IDLE.
REQ-021 Output reset values SHALL be:
- o_beat_valid, o_beat_last, o_cmd_err, o_busy: 0.
- o_beat_addr, o_beat_id, o_beat_idx: 0.
- o_cmd_ready: 0 while i_rst_n is 0; 1 in the first cycle after release.
REQ-022 Reset asserted mid-burst SHALL abandon the burst; no stale beat SHALL appear after release.

Verification (AW=32, DW=32)
REQ-023 INCR, addr 0x1002, len 3, size 2, i_beat_ready held 1 -> addresses 0x1002, 0x1004, 0x1008, 0x100C; o_beat_last on 0x100C; o_busy low the next cycle.
REQ-024 WRAP, addr 0x1034, len 3, size 2 -> 0x1034, 0x1038, 0x103C, 0x1030; FIXED, addr 0x2000, len 2 -> 0x2000 three times.
REQ-025 INCR, addr 0x1FF8, len 3, size 2 -> 0x1FF8, 0x1FFC, 0x1000, 0x1004 (4 KB hold).
REQ-026 Backpressure and back-to-back:
- i_beat_ready toggling 1,0,0,1 keeps beat outputs stable while ready is 0.
- A second command presented during the last beat is accepted in that same cycle; its beat 0 follows in the next cycle with no gap.
REQ-027 Error cases -> accepted, o_cmd_err high for 1 cycle, o_beat_valid stays 0:
- WRAP with len 2.
- size 3 (exceeds DW=32).
REQ-028 Reset mid-burst: assert i_rst_n=0 at beat 1 of an INCR len 7 burst -> all outputs at reset values; after release, o_cmd_ready=1 and no stale beat appears.
